// File: rtl/piso_rr_arbiter_pkg.sv
// Shared definitions for the round-robin packet arbiter feeding a PISO serializer.
// Holds the FSM encoding and the default sizing used by the arbiter and its selector.
package piso_rr_arbiter_pkg;

  localparam int N_REQ_DEF      = 4;
  localparam int DATA_WIDTH_DEF = 256;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/piso_rr_arbiter_rr_select.sv
// Combinational round-robin search: first set bit of i_req at or above i_ptr,
// wrapping modulo N_REQ.
module piso_rr_arbiter_rr_select
  import piso_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [$clog2(N_REQ)-1:0] o_idx,
  output logic                     o_found
);

  localparam int GW = $clog2(N_REQ);

  int w_cand;

  // Walk offsets from the far end downward so the smallest offset from i_ptr wins.
  always_comb begin
    o_idx   = '0;
    o_found = |i_req;
    w_cand  = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= N_REQ) w_cand = w_cand - N_REQ;
      if (i_req[w_cand[GW-1:0]]) o_idx = w_cand[GW-1:0];
    end
  end

endmodule

// File: rtl/piso_rr_arbiter.sv
// Packet-locked round-robin arbiter from N_REQ word sources into one serializer input.
// state  | meaning
// IDLE   | no owner; one cycle spent picking the next requester from rr_ptr
// LOCKED | grant_id owns the serializer until its last word is transferred
module piso_rr_arbiter
  import piso_rr_arbiter_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ce,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0]              req_last,
  output logic [N_REQ-1:0]              req_ready,
  output logic [DATA_WIDTH-1:0]         piso_din,
  output logic                          piso_din_valid,
  input  logic                          piso_full,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic                          busy,
  output logic [31:0]                   pkt_count
);

  localparam int GW = $clog2(N_REQ);

  arb_state_e      r_state;
  arb_state_e      w_state_nxt;
  logic [GW-1:0]   r_grant_id;
  logic [GW-1:0]   r_rr_ptr;
  logic [31:0]     r_pkt_count;
  logic [GW-1:0]   w_sel_idx;
  logic            w_sel_found;
  logic            w_can_accept;
  logic            w_xfer;
  logic            w_pkt_done;
  logic [DATA_WIDTH-1:0] w_words [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign w_words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  piso_rr_arbiter_rr_select #(
    .N_REQ (N_REQ)
  ) u_rr_select (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_sel_idx),
    .o_found (w_sel_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (ce) begin
      r_state <= w_state_nxt;
    end
  end

  // rst also masks the handshake so an abandoned packet never writes in the reset cycle.
  always_comb begin
    w_state_nxt  = r_state;
    req_ready    = '0;
    w_can_accept = 1'b0;
    w_xfer       = 1'b0;
    w_pkt_done   = 1'b0;
    if (r_state == ST_IDLE) begin
      if (w_sel_found) w_state_nxt = ST_LOCKED;
    end else begin
      w_can_accept          = ce & ~piso_full & ~rst;
      req_ready[r_grant_id] = w_can_accept;
      w_xfer                = req_valid[r_grant_id] & w_can_accept;
      w_pkt_done            = w_xfer & req_last[r_grant_id];
      if (w_pkt_done) w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_id  <= '0;
      r_rr_ptr    <= '0;
      r_pkt_count <= '0;
    end else if (ce) begin
      if (r_state == ST_IDLE && w_sel_found) r_grant_id <= w_sel_idx;
      if (w_pkt_done) begin
        r_rr_ptr    <= (r_grant_id == GW'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
        r_pkt_count <= r_pkt_count + 32'd1;
      end
    end
  end

  assign piso_din       = w_words[r_grant_id];
  assign piso_din_valid = w_xfer;
  assign grant_id       = r_grant_id;
  assign busy           = (r_state == ST_LOCKED);
  assign pkt_count      = r_pkt_count;

endmodule

// File: tb/tb_piso_rr_arbiter.sv
// Bench for piso_rr_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a packet-level reference model.
module tb_piso_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            ce;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   piso_din;
  logic            piso_din_valid;
  logic            piso_full;
  logic [GW-1:0]   grant_id;
  logic            busy;
  logic [31:0]     pkt_count;

  piso_rr_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ce             (ce),
    .req_data       (req_data),
    .req_valid      (req_valid),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .piso_din       (piso_din),
    .piso_din_valid (piso_din_valid),
    .piso_full      (piso_full),
    .grant_id       (grant_id),
    .busy           (busy),
    .pkt_count      (pkt_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Requester side: each source streams consecutive words; rem is words left in its packet.
  logic [N-1:0] want_valid;
  bit           want_ce, want_full, want_rst;
  int           force_len [N];
  int           rem       [N];
  int           seq       [N];
  int           exp_next  [N];

  // Reference model: ownership, search pointer and completed-packet count.
  bit           m_locked;
  int           m_owner;
  int           m_ptr;
  logic [31:0]  m_cnt;

  int           log_gid [$];
  int           log_cyc [$];
  logic [DW-1:0] log_dat [$];

  function automatic logic [DW-1:0] word_of(input int i);
    return {8'(i), 24'(seq[i])};
  endfunction

  task automatic clear_log();
    log_gid.delete();
    log_cyc.delete();
    log_dat.delete();
  endtask

  task automatic set_lens(input int l0, input int l1, input int l2, input int l3);
    force_len[0] = l0; force_len[1] = l1; force_len[2] = l2; force_len[3] = l3;
  endtask

  task automatic step();
    logic [N-1:0] e_ready;
    bit           e_xfer;
    bit           found;
    int           id;
    int           j;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (rem[i] == 0) rem[i] = (force_len[i] > 0) ? force_len[i] : int'($urandom_range(4, 1));
      req_data[i*DW +: DW] = word_of(i);
      req_last[i]          = (rem[i] == 1);
    end
    req_valid = want_valid;
    ce        = want_ce;
    piso_full = want_full;
    rst       = want_rst;
    #1;
    e_ready = '0;
    e_xfer  = 1'b0;
    if (m_locked && !want_rst && want_ce && !want_full) begin
      e_ready[m_owner] = 1'b1;
      e_xfer           = want_valid[m_owner];
    end
    check_val("req_ready", req_ready, e_ready);
    check_val("din_valid", piso_din_valid, e_xfer);
    if (e_xfer) check_val("piso_din", piso_din, word_of(m_owner));
    check_val("busy", busy, m_locked);
    if (m_locked) check_val("grant_id", grant_id, m_owner);
    check_val("pkt_count", pkt_count, m_cnt);
    if (piso_din_valid === 1'b1) begin
      log_gid.push_back(int'(grant_id));
      log_cyc.push_back(cyc);
      log_dat.push_back(piso_din);
      id = int'(piso_din[31:24]);
      if (id < N) begin
        check_val("seq_order", piso_din[23:0], 24'(exp_next[id]));
        exp_next[id] = int'(piso_din[23:0]) + 1;
      end else begin
        check_val("src_id", id, 0);
      end
    end
    @(posedge clk);
    cyc++;
    if (want_rst) begin
      m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = '0;
      for (int i = 0; i < N; i++) rem[i] = 0;
    end else if (want_ce) begin
      if (e_xfer) begin
        if (rem[m_owner] == 1) begin
          m_locked = 1'b0;
          m_ptr    = (m_owner + 1) % N;
          m_cnt    = m_cnt + 32'd1;
        end
        seq[m_owner]++;
        rem[m_owner]--;
      end else if (!m_locked && want_valid != '0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (!found && want_valid[j]) begin
            m_owner = j;
            found   = 1'b1;
          end
        end
        m_locked = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    want_rst   = 1'b1;
    want_valid = '0;
    step();
    step();
    want_rst = 1'b0;
  endtask

  int c0;
  int base;
  int nlog;

  initial begin
    rst = 1'b1; ce = 1'b0; piso_full = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; seq[i] = 0; exp_next[i] = 0; force_len[i] = 0;
    end
    m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = '0;
    want_rst = 1'b0; want_ce = 1'b1; want_full = 1'b0; want_valid = '0;
    repeat (2) @(posedge clk);

    step();
    #2 check_val("rst_grant", grant_id, 0);

    // Single requester, 3-word packet.
    do_reset();
    set_lens(3, 0, 0, 0);
    clear_log();
    c0 = cyc; base = seq[0];
    want_valid = 4'b0001;
    repeat (4) step();
    want_valid = '0;
    step();
    #2 check_val("s1_pkts", pkt_count, 1);
    check_val("s1_nwr", log_gid.size(), 3);
    for (int k = 0; k < 3 && k < log_gid.size(); k++) begin
      check_val("s1_cyc", log_cyc[k], c0 + 1 + k);
      check_val("s1_dat", log_dat[k], {8'd0, 24'(base + k)});
    end
    set_lens(1, 1, 0, 0);
    clear_log();
    want_valid = 4'b0011;
    repeat (2) step();
    want_valid = '0;
    check_val("s1_ptr_n", log_gid.size(), 1);
    if (log_gid.size() > 0) check_val("s1_ptr", log_gid[0], 1);

    // Contention: every requester sends 1-word packets.
    do_reset();
    set_lens(1, 1, 1, 1);
    clear_log();
    c0 = cyc;
    want_valid = 4'b1111;
    repeat (10) step();
    check_val("s2_nwr", log_gid.size(), 5);
    for (int k = 0; k < 5 && k < log_gid.size(); k++) begin
      check_val("s2_gid", log_gid[k], k % N);
      check_val("s2_cyc", log_cyc[k], c0 + 1 + 2 * k);
    end

    // Packet lock: owner drops valid mid-packet while another requester waits.
    do_reset();
    set_lens(0, 4, 2, 0);
    clear_log();
    want_valid = 4'b0010;
    repeat (3) step();
    want_valid = 4'b0100;
    repeat (5) step();
    want_valid = 4'b0110;
    repeat (8) step();
    check_val("s3_nwr", log_gid.size() >= 6, 1);
    if (log_gid.size() >= 6) begin
      for (int k = 0; k < 4; k++) check_val("s3_own1", log_gid[k], 1);
      check_val("s3_own2a", log_gid[4], 2);
      check_val("s3_own2b", log_gid[5], 2);
      check_val("s3_gap", log_cyc[2] - log_cyc[1], 6);
    end

    // Backpressure mid-packet.
    do_reset();
    set_lens(6, 0, 0, 0);
    clear_log();
    base = seq[0];
    want_valid = 4'b0001;
    repeat (3) step();
    want_full = 1'b1;
    repeat (4) step();
    check_val("s4_stall", log_gid.size(), 2);
    want_full = 1'b0;
    repeat (4) step();
    want_valid = '0;
    step();
    check_val("s4_nwr", log_gid.size(), 6);
    for (int k = 0; k < 6 && k < log_dat.size(); k++)
      check_val("s4_dat", log_dat[k], {8'd0, 24'(base + k)});

    // Reset in the middle of a 4-word packet.
    set_lens(0, 0, 0, 4);
    clear_log();
    want_valid = 4'b1000;
    repeat (2) step();
    want_rst = 1'b1;
    step();
    want_rst = 1'b0;
    check_val("s5_nwr", log_gid.size(), 1);
    #2;
    check_val("s5_busy", busy, 0);
    check_val("s5_pkts", pkt_count, 0);
    check_val("s5_gid", grant_id, 0);
    set_lens(1, 1, 1, 1);
    clear_log();
    want_valid = 4'b1111;
    repeat (3) step();
    check_val("s5_first_n", log_gid.size() > 0, 1);
    if (log_gid.size() > 0) check_val("s5_first", log_gid[0], 0);

    // Clock-enable gating while locked.
    do_reset();
    set_lens(0, 0, 5, 0);
    clear_log();
    want_valid = 4'b0100;
    repeat (2) step();
    nlog = log_gid.size();
    want_ce = 1'b0;
    repeat (3) step();
    #2;
    check_val("s6_nwr", log_gid.size(), nlog);
    check_val("s6_busy", busy, 1);
    check_val("s6_pkts", pkt_count, 0);
    want_ce = 1'b1;
    repeat (5) step();
    #2 check_val("s6_pkts_end", pkt_count, 1);

    // Random traffic.
    do_reset();
    set_lens(0, 0, 0, 0);
    want_valid = '0;
    repeat (3000) begin
      for (int i = 0; i < N; i++) want_valid[i] = ($urandom_range(99) < 70);
      want_full = ($urandom_range(99) < 20);
      want_ce   = ($urandom_range(99) < 90);
      want_rst  = ($urandom_range(299) == 0);
      step();
    end
    want_rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
